player_cmd_sequencer: RTL and testbench
=======================================

// Module: player_cmd_sequencer
// PURPOSE
//  Sits directly upstream of the player-state block; sole driver of its 16-bit instruction bus.
//  Merges held direction keys with queued combat events (heal/damage/ATK), one instruction per clk.
//  Runs the init sequence after reset/restart and suppresses traffic while the player is dead.
//  Instruction format: [15:12] opcode, [11:4] operand, [3:0] = 0; all-zero = NOP.
// PARAMETERS
//  DEPTH          4    event FIFO entries (power of 2, >=2)
//  MOVE_DIV       16   clk cycles per movement tick (>=2)
//  INIT_HP        100  operand of init SET_HP
//  INIT_ATK       10   operand of init SET_ATK
//  IFRAME_CYCLES  32   invulnerability window length (used only with PLAYER_IFRAME_EN)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  key_i       in   4   held keys: [0] x-, [1] y-, [2] x+, [3] y+
//  evt_valid   in   1   combat event valid
//  evt_ready   out  1   FIFO can accept (= !full)
//  evt_data    in   12  {opcode[11:8], operand[7:0]}
//  restart_i   in   1   one-cycle game restart pulse
//  is_death_i  in   1   death flag from player-state block
//  instr_o     out  16  registered instruction to player-state block
//  state_o     out  2   FSM state (debug/HUD)
//  iframe_o    out  1   invulnerability active (tied 0 when feature off)
// BEHAVIOUR
//  Reset: instr_o=0, state=INIT, FIFO empty, tick counter=0, move_pending=0, rr pointer=0, iframe_o=0.
//  Event handshake: push when evt_valid&&evt_ready; push and pop same cycle allowed when not full.
//  Legal event opcodes 1,2,3,4,6; any other opcode is pushed, then popped silently (no instr, no stall).
//  FSM INIT: cycle 0 instr_o={4'h6,INIT_HP,4'h0}; cycle 1 {4'h4,INIT_ATK,4'h0}; then RUN. FIFO flushed on entry.
//  FSM RUN, per cycle priority: (1) FIFO head legal -> emit, pop; (2) move_pending && any key -> emit move; (3) NOP.
//  Move: {4'h5, dir, 4'h0}, dir 0..3; multiple keys held -> round-robin from rr pointer, pointer advances past granted dir.
//  Tick counter free-runs 0..MOVE_DIV-1; wrap sets move_pending; cleared when move emitted or no key held at wrap.
//  Deferred move (event won) issues on first free cycle; never more than one pending move.
//  RUN -> DEAD when is_death_i sampled 1; evaluated only in RUN (ignored in INIT).
//  DEAD: instr_o=NOP, evt_ready=1, all pushed events discarded, move_pending cleared.
//  restart_i in RUN or DEAD -> INIT next cycle; restart_i during INIT restarts the sequence at cycle 0.
//  Async reset mid-sequence: immediate reset values; init sequence replays after release.
//  instr_o is a pulse: valid for exactly the one cycle it is issued, NOP otherwise.
// CONFIGURATION
//  PLAYER_IFRAME_EN defined: emitting damage (op 2) loads iframe counter with IFRAME_CYCLES;
//   while nonzero, damage at FIFO head is popped and dropped, iframe_o=1; heal/ATK unaffected; cleared on INIT.
//  PLAYER_IFRAME_EN undefined: every damage event forwarded; iframe_o constant 0; no counter logic.
// STRUCTURE
//  player_cmd_pkg: opcode constants (NOP,HEAL,DMG,ATK_ADD,ATK_SET,MOVE,HP_SET), direction codes, FSM enum
//   {INIT,RUN,DEAD}, instr pack function.
//  Sub-module player_cmd_fifo: DEPTH x 12 sync FIFO, push/pop/flush, full/empty.
// TESTING
//  Release rst_n -> instr_o 16'h6640 then 16'h40A0, then NOP, state_o=RUN.
//  MOVE_DIV=4, key_i=4'b0100 held -> 16'h5020 once every 4 cycles, NOP between.
//  key_i=4'b0101 held -> alternating 16'h5000 / 16'h5020 on successive ticks.
//  Event 12'h205 arrives on tick cycle -> 16'h2050 first, deferred move next cycle.
//  DEPTH=4, 5 back-to-back events with moves held -> evt_ready low after 4th; all 4 emitted in order.
//  is_death_i=1 in RUN -> DEAD, event 12'h10A dropped, NOP; restart_i -> 16'h6640, 16'h40A0.
//  PLAYER_IFRAME_EN, IFRAME_CYCLES=8: two 12'h205 events 2 cycles apart -> single 16'h2050, iframe_o high 8 cycles.

Source files
------------

// File: rtl/player_cmd_pkg.sv
// player_cmd_pkg: opcodes, direction codes, FSM states and instruction packing for the player command sequencer
package player_cmd_pkg;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_HEAL    = 4'h1;
    localparam logic [3:0] OP_DMG     = 4'h2;
    localparam logic [3:0] OP_ATK_ADD = 4'h3;
    localparam logic [3:0] OP_ATK_SET = 4'h4;
    localparam logic [3:0] OP_MOVE    = 4'h5;
    localparam logic [3:0] OP_HP_SET  = 4'h6;

    localparam logic [1:0] DIR_XN = 2'd0;
    localparam logic [1:0] DIR_YN = 2'd1;
    localparam logic [1:0] DIR_XP = 2'd2;
    localparam logic [1:0] DIR_YP = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    function automatic logic [15:0] pack_instr(input logic [3:0] op, input logic [7:0] arg);
        return {op, arg, 4'h0};
    endfunction

    function automatic logic legal_evt_op(input logic [3:0] op);
        return op inside {OP_HEAL, OP_DMG, OP_ATK_ADD, OP_ATK_SET, OP_HP_SET};
    endfunction

endpackage

// File: rtl/player_cmd_sequencer_fifo.sv
// player_cmd_fifo: DEPTH x W synchronous event FIFO with push, pop and flush
module player_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign dout_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer/count update; flush wins over a same-cycle push or pop
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = din_i;
                wr_d        = wr_q + AW'(1);
            end
            if (pop_ok) rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/player_cmd_sequencer.sv
// player_cmd_sequencer: merges held movement keys and queued combat events into one instruction per cycle;
// optional invulnerability window enabled by PLAYER_IFRAME_EN
module player_cmd_sequencer
    import player_cmd_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int MOVE_DIV      = 16,
    parameter int INIT_HP       = 100,
    parameter int INIT_ATK      = 10,
    parameter int IFRAME_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_i,
    input  logic        evt_valid,
    output logic        evt_ready,
    input  logic [11:0] evt_data,
    input  logic        restart_i,
    input  logic        is_death_i,
    output logic [15:0] instr_o,
    output logic [1:0]  state_o,
    output logic        iframe_o
);

    localparam int TW = $clog2(MOVE_DIV);

    state_t        state_q, state_d;
    logic          step_q, step_d;
    logic [15:0]   instr_q, instr_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          pend_q, pend_d;
    logic [1:0]    rr_q, rr_d;
    logic [1:0]    dir;
    logic [11:0]   head;
    logic          full, empty, push, pop, flush, drop, emit_evt, mv, wrap, any_key;

    assign instr_o   = instr_q;
    assign state_o   = state_q;
    assign evt_ready = (state_q == ST_DEAD) ? 1'b1 : !full;
    assign push      = evt_valid && !full && state_q != ST_DEAD;
    assign flush     = (restart_i && state_q != ST_INIT) || state_q == ST_DEAD;
    assign wrap      = tick_q == TW'(MOVE_DIV - 1);
    assign any_key   = |key_i;

    player_cmd_fifo #(.DEPTH(DEPTH), .W(12)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (evt_data),
        .pop_i   (pop),
        .flush_i (flush),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef PLAYER_IFRAME_EN
    localparam int IW = $clog2(IFRAME_CYCLES + 1);
    logic [IW-1:0] ifr_q, ifr_d;

    assign iframe_o = ifr_q != '0;
    assign drop     = iframe_o && head[11:8] == OP_DMG;

    // Invulnerability countdown, reloaded by each forwarded damage event
    always_comb begin
        ifr_d = (state_q == ST_INIT) ? '0 :
                (emit_evt && head[11:8] == OP_DMG) ? IW'(IFRAME_CYCLES) :
                iframe_o ? ifr_q - IW'(1) : ifr_q;
    end

    // Invulnerability counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ifr_q <= '0;
        else        ifr_q <= ifr_d;
    end
`else
    logic unused_ifr;
    assign unused_ifr = ^IFRAME_CYCLES;
    assign iframe_o   = 1'b0;
    assign drop       = 1'b0;
`endif

    // Round-robin pick of the first held key at or after the rr pointer
    always_comb begin
        dir = rr_q;
        for (int i = 3; i >= 0; i--) if (key_i[rr_q + 2'(i)]) dir = rr_q + 2'(i);
    end

    // FSM next state and instruction selection
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        instr_d  = pack_instr(OP_NOP, 8'h00);
        pop      = 1'b0;
        emit_evt = 1'b0;
        mv       = 1'b0;
        if (state_q == ST_INIT) begin
            if (restart_i) begin
                step_d = 1'b0;
            end else if (!step_q) begin
                instr_d = pack_instr(OP_HP_SET, 8'(INIT_HP));
                step_d  = 1'b1;
            end else begin
                instr_d = pack_instr(OP_ATK_SET, 8'(INIT_ATK));
                step_d  = 1'b0;
                state_d = ST_RUN;
            end
        end else if (restart_i) begin
            state_d = ST_INIT;
            step_d  = 1'b0;
        end else if (state_q == ST_RUN) begin
            state_d  = is_death_i ? ST_DEAD : ST_RUN;
            pop      = !empty;
            emit_evt = !empty && legal_evt_op(head[11:8]) && !drop;
            mv       = !emit_evt && pend_q && any_key;
            instr_d  = emit_evt ? {head, 4'h0} : mv ? pack_instr(OP_MOVE, {6'b0, dir}) : instr_d;
        end
    end

    // Movement tick, pending-move flag and round-robin pointer
    always_comb begin
        tick_d = wrap ? '0 : tick_q + TW'(1);
        pend_d = (state_q == ST_DEAD) ? 1'b0 : wrap ? any_key : mv ? 1'b0 : pend_q;
        rr_d   = mv ? dir + 2'd1 : rr_q;
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            step_q  <= 1'b0;
            instr_q <= '0;
            tick_q  <= '0;
            pend_q  <= 1'b0;
            rr_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            instr_q <= instr_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_player_cmd_sequencer.sv
// tb_player_cmd_sequencer: directed self-checking bench for player_cmd_sequencer (MOVE_DIV=4, DEPTH=4, IFRAME_CYCLES=8)
module tb_player_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key_i;
    logic        evt_valid;
    logic        evt_ready;
    logic [11:0] evt_data;
    logic        restart_i;
    logic        is_death_i;
    logic [15:0] instr_o;
    logic [1:0]  state_o;
    logic        iframe_o;
    int          n_chk = 0;
    int          n_fail = 0;

    player_cmd_sequencer #(
        .DEPTH(4), .MOVE_DIV(4), .INIT_HP(100), .INIT_ATK(10), .IFRAME_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_i(key_i), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .restart_i(restart_i), .is_death_i(is_death_i),
        .instr_o(instr_o), .state_o(state_o), .iframe_o(iframe_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_instr(input string tag, input logic [15:0] v, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (instr_o !== v && n < budget);
        chk(tag, instr_o, v);
    endtask

    initial begin
        rst_n = 1'b0; key_i = 4'b0; evt_valid = 1'b0; evt_data = 12'h0; restart_i = 1'b0; is_death_i = 1'b0;
        tick();
        tick();
        chk("rst_instr", instr_o, 16'h0000);
        chk("rst_state", 16'(state_o), 16'd0);
        chk("rst_iframe", 16'(iframe_o), 16'd0);
        chk("rst_ready", 16'(evt_ready), 16'd1);
        rst_n = 1'b1;
        tick(); chk("init_hp", instr_o, 16'h6640);
        tick(); chk("init_atk", instr_o, 16'h40A0);
        chk("run_state", 16'(state_o), 16'd1);
        tick(); chk("run_nop", instr_o, 16'h0000);
        tick();
        key_i = 4'b0100;
        wait_instr("move_first", 16'h5020, 12);
        for (int i = 0; i < 4; i++) begin
            tick(); chk("move_period", instr_o, (i == 3) ? 16'h5020 : 16'h0000);
        end
        key_i = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            tick(); chk("move_rr", instr_o, (i == 3) ? 16'h5000 : (i == 7) ? 16'h5020 : 16'h0000);
        end
        tick();
        tick();
        evt_valid = 1'b1; evt_data = 12'h205;
        tick(); chk("evt_tick_nop", instr_o, 16'h0000);
        evt_valid = 1'b0;
        tick(); chk("evt_wins", instr_o, 16'h2050);
        tick(); chk("move_deferred", instr_o, 16'h5000);
        tick(); chk("after_deferred", instr_o, 16'h0000);
        restart_i = 1'b1;
        tick(); chk("restart_nop", instr_o, 16'h0000);
        chk("restart_state", 16'(state_o), 16'd0);
        evt_valid = 1'b1;
        evt_data = 12'h111; tick();
        evt_data = 12'h322; tick();
        evt_data = 12'h433; tick();
        chk("ready_3", 16'(evt_ready), 16'd1);
        evt_data = 12'h644; tick();
        chk("ready_full", 16'(evt_ready), 16'd0);
        evt_data = 12'h155; tick();
        evt_valid = 1'b0; restart_i = 1'b0;
        tick(); chk("fill_init_hp", instr_o, 16'h6640);
        tick(); chk("fill_init_atk", instr_o, 16'h40A0);
        tick(); chk("fifo_0", instr_o, 16'h1110);
        tick(); chk("fifo_1", instr_o, 16'h3220);
        tick(); chk("fifo_2", instr_o, 16'h4330);
        tick(); chk("fifo_3", instr_o, 16'h6440);
        tick();
        n_chk++;
        assert (instr_o !== 16'h1550) else begin
            n_fail++;
            $error("FAIL fifo_overflow: observed %h required not 1550", instr_o);
        end
        key_i = 4'b0;
        tick(); tick(); tick();
        evt_valid = 1'b1; evt_data = 12'h7AB;
        tick();
        evt_data = 12'h3CC;
        tick();
        evt_valid = 1'b0;
        tick(); chk("illegal_skipped", instr_o, 16'h3CC0);
        is_death_i = 1'b1;
        tick(); chk("dead_state", 16'(state_o), 16'd2);
        evt_valid = 1'b1; evt_data = 12'h10A;
        chk("dead_ready", 16'(evt_ready), 16'd1);
        tick(); chk("dead_nop0", instr_o, 16'h0000);
        evt_valid = 1'b0;
        tick(); chk("dead_nop1", instr_o, 16'h0000);
        is_death_i = 1'b0; restart_i = 1'b1;
        tick(); chk("dead_restart", 16'(state_o), 16'd0);
        restart_i = 1'b0;
        tick(); chk("dead_init_hp", instr_o, 16'h6640);
        tick(); chk("dead_init_atk", instr_o, 16'h40A0);
        tick(); chk("dead_evt_gone", instr_o, 16'h0000);
        evt_valid = 1'b1; evt_data = 12'h205;
        tick();
        evt_valid = 1'b0;
        tick(); chk("dmg_first", instr_o, 16'h2050);
        evt_valid = 1'b1;
        tick();
        evt_valid = 1'b0;
        tick();
`ifdef PLAYER_IFRAME_EN
        chk("dmg_second_dropped", instr_o, 16'h0000);
        chk("iframe_on", 16'(iframe_o), 16'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("iframe_last", 16'(iframe_o), 16'd1);
        tick(); chk("iframe_off", 16'(iframe_o), 16'd0);
`else
        chk("dmg_second", instr_o, 16'h2050);
        chk("iframe_tied", 16'(iframe_o), 16'd0);
`endif
        rst_n = 1'b0;
        #2;
        chk("async_rst_instr", instr_o, 16'h0000);
        chk("async_rst_state", 16'(state_o), 16'd0);
        tick();
        rst_n = 1'b1;
        tick(); chk("replay_hp", instr_o, 16'h6640);
        tick(); chk("replay_atk", instr_o, 16'h40A0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
